// File: rtl/trigger_event_recorder.sv
// trigger_event_recorder
// Samples the trigger stream (l1a, alct_dav, tmb_dav, lct) every enabled
// cycle, timestamps it with a free-running counter and queues each non-idle
// sample in a first-word-fall-through FIFO drained through valid/ready.
module trigger_event_recorder #(
  parameter int TS_WIDTH  = 32,
  parameter int LCT_WIDTH = 8,
  parameter int FIFO_AW   = 4,
  parameter int OVF_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             l1a,
  input  logic                             alct_dav,
  input  logic                             tmb_dav,
  input  logic [LCT_WIDTH-1:0]             lct,
  output logic [TS_WIDTH+LCT_WIDTH+3-1:0]  rec_data,
  output logic                             rec_valid,
  input  logic                             rec_ready,
  output logic [FIFO_AW:0]                 fifo_count,
  output logic                             overflow,
  output logic [OVF_WIDTH-1:0]             overflow_cnt
);

  localparam int              REC_W   = TS_WIDTH + LCT_WIDTH + 3;
  localparam int              DEPTH_I = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH  = (FIFO_AW+1)'(DEPTH_I);

  logic [TS_WIDTH-1:0]  ts_cnt_q,   ts_cnt_d;
  logic [FIFO_AW-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [FIFO_AW:0]     count_q,    count_d;
  logic [REC_W-1:0]     rec_data_q, rec_data_d;
  logic                 overflow_q, overflow_d;
  logic [OVF_WIDTH-1:0] ovf_cnt_q,  ovf_cnt_d;

  logic [REC_W-1:0]     mem [DEPTH_I];

  logic                 event_hit;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [FIFO_AW:0]     remain;
  logic [REC_W-1:0]     rec_word;

  // Event detection, push/pop arbitration and next-state for all control state
  always_comb begin
    event_hit  = en & (l1a | alct_dav | tmb_dav | (|lct));
    pop        = (count_q != '0) & rec_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    push       = event_hit & ((count_q != DEPTH) | pop);
    drop       = event_hit & ~push;
    rec_word   = {ts_cnt_q, l1a, alct_dav, tmb_dav, lct};

    ts_cnt_d   = en ? ts_cnt_q + TS_WIDTH'(1) : ts_cnt_q;
    wr_ptr_d   = wr_ptr_q + FIFO_AW'(push);
    rd_ptr_d   = rd_ptr_q + FIFO_AW'(pop);
    count_d    = count_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);

    // Registered head: entries left after the pop come from RAM; if none are
    // left, the record being written this cycle bypasses RAM straight to the head
    remain     = count_q - (FIFO_AW+1)'(pop);
    rec_data_d = rec_data_q;
    if (remain == '0) begin
      if (push) begin
        rec_data_d = rec_word;
      end
    end else begin
      rec_data_d = mem[rd_ptr_d];
    end

    overflow_d = overflow_q | drop;
    ovf_cnt_d  = ovf_cnt_q;
    if (drop && (ovf_cnt_q != '1)) begin
      ovf_cnt_d = ovf_cnt_q + OVF_WIDTH'(1);
    end
  end

  // Control and head registers; reset flushes the queue and clears the timestamp
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rec_data_q <= '0;
      overflow_q <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      ts_cnt_q   <= ts_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rec_data_q <= rec_data_d;
      overflow_q <= overflow_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  // Record storage; only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr_q] <= rec_word;
    end
  end

  assign rec_data     = rec_data_q;
  assign rec_valid    = (count_q != '0);
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;
  assign overflow_cnt = ovf_cnt_q;

endmodule
